// File: rtl/sb_tx_pkg.sv
// Shared sideband TX definitions: packet geometry, idle gap length and serializer states.
package sb_tx_pkg;

    localparam int unsigned SB_PKT_W  = 64;
    localparam int unsigned SB_GAP_UI = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } sb_ser_state_e;

    function automatic int unsigned sb_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: shifts one framed packet per handshake onto TXDATASB,
// gates the forwarded clock to data UI only and enforces a low idle gap between packets.
module sb_tx_serializer
    import sb_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = SB_PKT_W,
    parameter int unsigned GAP_UI    = SB_GAP_UI,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    output logic              o_txdatasb,
    output logic              o_clk_gate_en,
    output logic              o_ser_done,
    output logic              o_busy,
    output logic [7:0]        o_pkt_cnt
);

    localparam int unsigned      CntW       = $clog2(sb_max(DATA_W, GAP_UI));
    localparam logic [CntW-1:0]  BitLast    = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0]  GapLast    = CntW'(GAP_UI - 1);
    localparam logic [CntW-1:0]  GapPreLast = CntW'(GAP_UI - 2);

    sb_ser_state_e     state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CntW-1:0]   gap_cnt_q, gap_cnt_d;
    logic              txd_q, txd_d;
    logic              gate_q, gate_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [7:0]        pkt_cnt_q, pkt_cnt_d;

    logic              xfer;
    logic              start;
    logic              load_bit;
    logic [DATA_W-1:0] load_rest;
    logic              next_bit;
    logic [DATA_W-1:0] next_rest;

    assign xfer = i_data_valid && ready_q;

    // First UI is emitted straight from i_data; the register keeps only what is left.
    always_comb begin
        if (LSB_FIRST) begin
            load_bit  = i_data[0];
            load_rest = i_data >> 1;
            next_bit  = shift_q[0];
            next_rest = shift_q >> 1;
        end else begin
            load_bit  = i_data[DATA_W-1];
            load_rest = i_data << 1;
            next_bit  = shift_q[DATA_W-1];
            next_rest = shift_q << 1;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        txd_d     = 1'b0;
        gate_d    = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        start     = 1'b0;

        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                start   = xfer;
            end
            SHIFT: begin
                if (bit_cnt_q == BitLast) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                    done_d    = 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 8'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shift_d   = next_rest;
                    txd_d     = next_bit;
                    gate_d    = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GapLast) begin
                    start = xfer;
                    if (!xfer) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                    // Ready is registered, so raise it one cycle ahead of the last gap UI.
                    ready_d   = (gap_cnt_q == GapPreLast);
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d   = SHIFT;
            shift_d   = load_rest;
            bit_cnt_d = '0;
            txd_d     = load_bit;
            gate_d    = 1'b1;
            ready_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            txd_q     <= 1'b0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            txd_q     <= txd_d;
            gate_q    <= gate_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign o_data_ready  = ready_q;
    assign o_txdatasb    = txd_q;
    assign o_clk_gate_en = gate_q;
    assign o_ser_done    = done_q;
    assign o_busy        = (state_q != IDLE);
    assign o_pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer: LSB-first instance u0 plus an MSB-first instance u1.
module tb_sb_tx_serializer;

    logic        clk;
    logic        rst_n;
    logic [63:0] data0, data1;
    logic        valid0, valid1;
    logic        ready0, ready1;
    logic        txd0, txd1;
    logic        gate0, gate1;
    logic        done0, done1;
    logic        busy0, busy1;
    logic [7:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    sb_tx_serializer #(.DATA_W(64), .GAP_UI(32), .LSB_FIRST(1'b1)) u0 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data        (data0),
        .i_data_valid  (valid0),
        .o_data_ready  (ready0),
        .o_txdatasb    (txd0),
        .o_clk_gate_en (gate0),
        .o_ser_done    (done0),
        .o_busy        (busy0),
        .o_pkt_cnt     (cnt0)
    );

    sb_tx_serializer #(.DATA_W(64), .GAP_UI(32), .LSB_FIRST(1'b0)) u1 (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data        (data1),
        .i_data_valid  (valid1),
        .o_data_ready  (ready1),
        .o_txdatasb    (txd1),
        .o_clk_gate_en (gate1),
        .o_ser_done    (done1),
        .o_busy        (busy1),
        .o_pkt_cnt     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples 64 UI of u0 starting at the current (first data) cycle.
    task automatic collect0(output logic [63:0] rx, output int gcnt, output int rcnt);
        gcnt = 0;
        rcnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) tick();
            rx[i] = txd0;
            gcnt += int'(gate0);
            rcnt += int'(ready0);
        end
    endtask

    task automatic wait_ready0(output int n);
        n = 0;
        while (!ready0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    logic [63:0] rx, rxa, rxb;
    logic [63:0] msb_words [2];
    logic [63:0] msb_exp [2];
    int gcnt, rcnt, n, c, fr, gh, gl, xf, dn, cyc, t0, tl;

    initial begin
        rst_n  = 1'b0;
        data0  = '0;
        data1  = '0;
        valid0 = 1'b0;
        valid1 = 1'b0;
        msb_words[0] = 64'h8000_0000_0000_0000;
        msb_words[1] = 64'h8000_0000_0000_0003;
        msb_exp[0]   = 64'h0000_0000_0000_0001;
        msb_exp[1]   = 64'hC000_0000_0000_0001;

        // Reset state
        tick();
        tick();
        chk("rst_ready", 64'(ready0), 64'd0);
        chk("rst_txd", 64'(txd0), 64'd0);
        chk("rst_gate", 64'(gate0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_cnt", 64'(cnt0), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", 64'(ready0), 64'd1);

        // Single packet; i_data changes after the transfer must be ignored
        data0  = 64'h0000_0000_0000_0001;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        data0  = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("sp_busy", 64'(busy0), 64'd1);
        collect0(rx, gcnt, rcnt);
        chk("sp_stream", rx, 64'h0000_0000_0000_0001);
        chk("sp_gate_cnt", 64'(gcnt), 64'd64);
        chk("sp_ready_shift", 64'(rcnt), 64'd0);
        tick();
        chk("sp_done", 64'(done0), 64'd1);
        chk("sp_cnt", 64'(cnt0), 64'd1);
        chk("sp_gate_gap", 64'(gate0), 64'd0);
        chk("sp_ready_gap", 64'(ready0), 64'd0);
        wait_ready0(n);
        chk("sp_gap_len", 64'(n), 64'd31);
        tick();
        chk("sp_idle_busy", 64'(busy0), 64'd0);
        chk("sp_idle_ready", 64'(ready0), 64'd1);
        chk("sp_done_once", 64'(done0), 64'd0);

        // Back-to-back with valid held
        data0  = 64'hA5A5_A5A5_A5A5_A5A5;
        valid0 = 1'b1;
        tick();
        data0  = 64'h5A5A_5A5A_5A5A_5A5A;
        c = 1; fr = 0; gh = 0; gl = 0; rxa = '0;
        while (c < 200) begin
            if (c <= 64) rxa[c-1] = txd0;
            if (gate0) gh++;
            else gl++;
            if (ready0) begin
                fr = c;
                break;
            end
            tick();
            c++;
        end
        chk("b2b_xfer_cycle", 64'(fr), 64'd96);
        chk("b2b_gate_hi", 64'(gh), 64'd64);
        chk("b2b_gate_lo", 64'(gl), 64'd32);
        chk("b2b_word_a", rxa, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();
        valid0 = 1'b0;
        data0  = 64'h0;
        collect0(rxb, gcnt, rcnt);
        chk("b2b_word_b", rxb, 64'h5A5A_5A5A_5A5A_5A5A);
        tick();
        chk("b2b_done", 64'(done0), 64'd1);
        chk("b2b_cnt", 64'(cnt0), 64'd3);

        // Starved gap: valid arrives 10 cycles after the gap ends
        wait_ready0(n);
        tick();
        chk("stv_idle", 64'(busy0), 64'd0);
        repeat (9) tick();
        chk("stv_idle_hold", 64'(busy0), 64'd0);
        chk("stv_ready", 64'(ready0), 64'd1);
        data0  = 64'h0123_4567_89AB_CDEF;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        chk("stv_first_gate", 64'(gate0), 64'd1);
        chk("stv_first_ui", 64'(txd0), 64'd1);
        collect0(rx, gcnt, rcnt);
        chk("stv_stream", rx, 64'h0123_4567_89AB_CDEF);
        tick();
        chk("stv_cnt", 64'(cnt0), 64'd4);

        // Reset in the middle of SHIFT, at bit 20 (a one)
        wait_ready0(n);
        tick();
        data0  = 64'h0000_0000_0010_0000;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        repeat (20) tick();
        chk("mid_bit20", 64'(txd0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_txd", 64'(txd0), 64'd0);
        chk("mid_gate", 64'(gate0), 64'd0);
        chk("mid_busy", 64'(busy0), 64'd0);
        chk("mid_cnt", 64'(cnt0), 64'd0);
        chk("mid_ready", 64'(ready0), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mid_rel_ready", 64'(ready0), 64'd1);
        data0  = 64'hDEAD_BEEF_0123_4567;
        valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        collect0(rx, gcnt, rcnt);
        chk("mid_next_stream", rx, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("mid_next_done", 64'(done0), 64'd1);
        chk("mid_next_cnt", 64'(cnt0), 64'd1);

        // MSB-first instance
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (!ready1 && n < 200) begin
                tick();
                n++;
            end
            data1  = msb_words[k];
            valid1 = 1'b1;
            tick();
            valid1 = 1'b0;
            gcnt = 0;
            for (int i = 0; i < 64; i++) begin
                if (i > 0) tick();
                rx[i] = txd1;
                gcnt += int'(gate1);
            end
            chk($sformatf("msb_stream%0d", k), rx, msb_exp[k]);
            chk($sformatf("msb_gate%0d", k), 64'(gcnt), 64'd64);
            tick();
            chk($sformatf("msb_done%0d", k), 64'(done1), 64'd1);
            chk($sformatf("msb_cnt%0d", k), 64'(cnt1), 64'(k + 1));
            chk($sformatf("msb_busy%0d", k), 64'(busy1), 64'd1);
        end

        // Counter wrap over 256 back-to-back packets
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        data0  = 64'hF0F0_0F0F_1234_8765;
        valid0 = 1'b1;
        xf = 0; dn = 0; cyc = 0; t0 = 0; tl = 0;
        while (dn < 256 && cyc < 30000) begin
            if (ready0 && valid0) begin
                xf++;
                if (xf == 1) t0 = cyc;
            end
            tick();
            cyc++;
            if (xf == 256) valid0 = 1'b0;
            if (done0) begin
                dn++;
                tl = cyc;
                if (dn == 255) chk("wrap_cnt255", 64'(cnt0), 64'd255);
            end
        end
        chk("wrap_xfers", 64'(xf), 64'd256);
        chk("wrap_dones", 64'(dn), 64'd256);
        chk("wrap_cnt", 64'(cnt0), 64'd0);
        chk("wrap_span", 64'(tl - t0), 64'(65 + 255 * 96));
        wait_ready0(n);
        tick();
        chk("wrap_idle", 64'(busy0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
